fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_write_arbiter.sv | 147 ++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// Round-robin burst arbiter merging NREQ writers onto one FIFO write port.
// Define FIFO_WARB_STATS_EN to add per-requester write counters and a stall counter.
module fifo_write_arbiter #(
  parameter int WIDTH     = 8,
  parameter int NREQ      = 4,
  parameter int BURST_LEN = 4
) (
  input  logic                    WCLK,
  input  logic                    WRST,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   req_data,
  output logic [NREQ-1:0]         gnt,
  input  logic                    WFULL,
  output logic                    WINC,
  output logic [WIDTH-1:0]        WDATA
`ifdef FIFO_WARB_STATS_EN
  ,
  input  logic                    stat_clr,
  output logic [NREQ*16-1:0]      stat_wr_cnt,
  output logic [15:0]             stat_stall_cnt
`endif
);

  localparam int IDX_W = $clog2(NREQ);
  localparam int CNT_W = $clog2(BURST_LEN + 1);
  localparam logic [CNT_W-1:0] BEAT_MAX = CNT_W'(BURST_LEN);
  localparam logic [CNT_W-1:0] BEAT_ONE = CNT_W'(1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [IDX_W-1:0] owner_q, owner_d;
  logic [IDX_W-1:0] last_gnt_q, last_gnt_d;
  logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
  logic [CNT_W-1:0] beat_next;

  logic [IDX_W-1:0] sel;
  logic [IDX_W-1:0] rr_sel;
  logic [IDX_W-1:0] rr_cand;
  int               rr_pos;
  int               data_base;
  logic             winc;
  logic             burst_cont;

  assign winc       = (|req) & ~WFULL & ~WRST;
  assign burst_cont = (state_q == BURST) && req[owner_q];
  assign beat_next  = beat_cnt_q + BEAT_ONE;

  // Scan downward so the nearest requester after last_gnt is the final write.
  always_comb begin
    rr_sel  = '0;
    rr_pos  = 0;
    rr_cand = '0;
    for (int k = NREQ; k >= 1; k--) begin
      rr_pos  = (int'(last_gnt_q) + k) % NREQ;
      rr_cand = IDX_W'(rr_pos);
      if (req[rr_cand]) rr_sel = rr_cand;
    end
  end

  assign sel = burst_cont ? owner_q : rr_sel;

  always_ff @(posedge WCLK or posedge WRST) begin
    if (WRST) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      beat_cnt_q <= '0;
      last_gnt_q <= LAST_RST;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      beat_cnt_q <= beat_cnt_d;
      last_gnt_q <= last_gnt_d;
    end
  end

  // A full FIFO freezes everything; an empty request vector ends any burst.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    beat_cnt_d = beat_cnt_q;
    last_gnt_d = last_gnt_q;
    if (winc) begin
      last_gnt_d = sel;
      if (burst_cont) begin
        beat_cnt_d = beat_next;
        if (beat_next == BEAT_MAX) state_d = IDLE;
      end else if (BURST_LEN > 1) begin
        owner_d    = sel;
        beat_cnt_d = BEAT_ONE;
        state_d    = BURST;
      end else begin
        state_d = IDLE;
      end
    end else if (!WFULL) begin
      state_d = IDLE;
    end
  end

  always_comb begin
    WINC      = winc;
    gnt       = '0;
    WDATA     = '0;
    data_base = int'(sel) * WIDTH;
    if (winc) begin
      gnt[sel] = 1'b1;
      WDATA    = req_data[data_base +: WIDTH];
    end
  end

`ifdef FIFO_WARB_STATS_EN
  logic [15:0] wr_cnt_q [NREQ];
  logic [15:0] wr_cnt_d [NREQ];
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      wr_cnt_d[i] = wr_cnt_q[i];
      if (stat_clr) wr_cnt_d[i] = '0;
      else if (gnt[i] && (wr_cnt_q[i] != 16'hFFFF)) wr_cnt_d[i] = wr_cnt_q[i] + 16'd1;
    end
    stall_cnt_d = stall_cnt_q;
    if (stat_clr) stall_cnt_d = '0;
    else if ((|req) && WFULL && (stall_cnt_q != 16'hFFFF)) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge WCLK or posedge WRST) begin
    if (WRST) begin
      for (int i = 0; i < NREQ; i++) wr_cnt_q[i] <= '0;
      stall_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NREQ; i++) wr_cnt_q[i] <= wr_cnt_d[i];
      stall_cnt_q <= stall_cnt_d;
    end
  end

  for (genvar g = 0; g < NREQ; g++) begin : g_stat_pack
    assign stat_wr_cnt[g*16 +: 16] = wr_cnt_q[g];
  end
  assign stat_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Directed plus randomized bench for fifo_write_arbiter against a grant-rule model.
// Stats checks are compiled in when FIFO_WARB_STATS_EN is defined.
module tb_fifo_write_arbiter;
  localparam int WIDTH = 8;
  localparam int NREQ  = 4;
  localparam int BLEN  = 4;

  logic                  WCLK = 1'b0;
  logic                  WRST;
  logic [NREQ-1:0]       req;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       gnt;
  logic                  WFULL;
  logic                  WINC;
  logic [WIDTH-1:0]      WDATA;
`ifdef FIFO_WARB_STATS_EN
  logic                  stat_clr;
  logic [NREQ*16-1:0]    stat_wr_cnt;
  logic [15:0]           stat_stall_cnt;
`endif

  fifo_write_arbiter #(.WIDTH(WIDTH), .NREQ(NREQ), .BURST_LEN(BLEN)) dut (
    .WCLK(WCLK), .WRST(WRST), .req(req), .req_data(req_data), .gnt(gnt),
    .WFULL(WFULL), .WINC(WINC), .WDATA(WDATA)
`ifdef FIFO_WARB_STATS_EN
    , .stat_clr(stat_clr), .stat_wr_cnt(stat_wr_cnt), .stat_stall_cnt(stat_stall_cnt)
`endif
  );

  always #5 WCLK = ~WCLK;

  int n_cmp = 0;
  int n_err = 0;

  // Model: who owns the current burst, how many beats it has used, who was granted last.
  int m_owner, m_beats, m_last, m_pick;
  bit m_cont;

  function automatic void model_pick();
    m_pick = -1;
    m_cont = 1'b0;
    if (WRST || WFULL || req == '0) return;
    if (m_owner >= 0 && req[m_owner] && m_beats < BLEN) begin
      m_pick = m_owner;
      m_cont = 1'b1;
      return;
    end
    for (int k = 1; k <= NREQ; k++) begin
      if (req[(m_last + k) % NREQ]) begin
        m_pick = (m_last + k) % NREQ;
        return;
      end
    end
  endfunction

  task automatic model_commit();
    if (WRST) begin
      m_owner = -1; m_beats = 0; m_last = NREQ - 1;
    end else if (m_pick >= 0) begin
      if (m_cont) m_beats++;
      else begin m_owner = m_pick; m_beats = 1; end
      m_last = m_pick;
    end else if (!WFULL) begin
      m_owner = -1;
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic settle();
    logic [NREQ-1:0] eg;
    logic [WIDTH-1:0] ed;
    #1;
    model_pick();
    eg = '0;
    ed = '0;
    if (m_pick >= 0) begin
      eg[m_pick] = 1'b1;
      ed = req_data[m_pick*WIDTH +: WIDTH];
    end
    chk("model_gnt", 32'(gnt), 32'(eg));
    chk("model_winc", 32'(WINC), 32'(m_pick >= 0));
    chk("model_wdata", 32'(WDATA), 32'(ed));
  endtask

  task automatic advance();
    @(posedge WCLK);
    model_commit();
    @(negedge WCLK);
  endtask

  task automatic do_reset();
    WRST = 1'b1;
    settle();
    advance();
    WRST = 1'b0;
  endtask

  initial begin
    logic [NREQ-1:0] one_hot;
    WRST = 1'b1; req = '0; req_data = '0; WFULL = 1'b0;
`ifdef FIFO_WARB_STATS_EN
    stat_clr = 1'b0;
`endif
    m_owner = -1; m_beats = 0; m_last = NREQ - 1; m_pick = -1; m_cont = 1'b0;
    @(negedge WCLK);

    // Reset state: outputs gated while WRST is high even with requests pending.
    req = 4'b1111; req_data = 32'hA5A5_A5A5;
    #1;
    chk("rst_winc", 32'(WINC), 32'd0);
    chk("rst_gnt", 32'(gnt), 32'd0);
    chk("rst_wdata", 32'(WDATA), 32'd0);
    advance();
    model_commit();
    WRST = 1'b0;

    // All requesters active: 4-beat bursts rotating 0,1,2,3,0.
    for (int c = 0; c < 17; c++) begin
      req_data = $urandom;
      settle();
      one_hot = '0;
      one_hot[(c / BLEN) % NREQ] = 1'b1;
      chk("rr_burst_gnt", 32'(gnt), 32'(one_hot));
      chk("rr_burst_winc", 32'(WINC), 32'd1);
      advance();
    end

    // Stall mid-burst for three cycles, then finish the burst.
    do_reset();
    req = 4'b0001; req_data = 32'h0000_0011;
    for (int c = 0; c < 2; c++) begin settle(); chk("stall_pre_gnt", 32'(gnt), 32'd1); advance(); end
    WFULL = 1'b1;
    for (int c = 0; c < 3; c++) begin
      settle();
      chk("stall_winc", 32'(WINC), 32'd0);
      chk("stall_gnt", 32'(gnt), 32'd0);
      advance();
    end
    WFULL = 1'b0;
    for (int c = 0; c < 2; c++) begin settle(); chk("stall_post_gnt", 32'(gnt), 32'd1); advance(); end
    chk("stall_beat_cnt", 32'(dut.beat_cnt_q), 32'd4);
    settle();
    chk("single_req_no_gap", 32'(gnt), 32'd1);
    advance();

    // Owner drops mid-burst: next requester granted in the same cycle.
    do_reset();
    req = 4'b0101; req_data = 32'h0044_0022;
    for (int c = 0; c < 2; c++) begin settle(); chk("drop_pre_gnt", 32'(gnt), 32'd1); advance(); end
    req = 4'b0100;
    settle();
    chk("drop_gnt2", 32'(gnt), 32'b0100);
    chk("drop_winc", 32'(WINC), 32'd1);
    advance();

    // Reset mid-burst of requester 2.
    do_reset();
    req = 4'b0100;
    for (int c = 0; c < 2; c++) begin settle(); advance(); end
    settle();
    chk("midrst_pre_winc", 32'(WINC), 32'd1);
    #2 WRST = 1'b1;
    #1;
    chk("midrst_winc", 32'(WINC), 32'd0);
    chk("midrst_gnt", 32'(gnt), 32'd0);
    advance();
    WRST = 1'b0;
    req = 4'b0101;
    settle();
    chk("midrst_first_gnt", 32'(gnt), 32'b0001);
    advance();

    // Data ordering for requester 1.
    do_reset();
    req = 4'b0010;
    for (int i = 0; i < 10; i++) begin
      req_data = $urandom;
      req_data[15:8] = 8'(i);
      settle();
      chk("data_seq", 32'(WDATA), 32'(i));
      advance();
    end
`ifdef FIFO_WARB_STATS_EN
    chk("stat_wr1", 32'(stat_wr_cnt[31:16]), 32'd10);
    req = 4'b0011; WFULL = 1'b1;
    for (int c = 0; c < 5; c++) begin settle(); advance(); end
    chk("stat_stall", 32'(stat_stall_cnt), 32'd5);
    stat_clr = 1'b1;
    settle();
    advance();
    stat_clr = 1'b0;
    chk("stat_clr_wr", 32'(|stat_wr_cnt), 32'd0);
    chk("stat_clr_stall", 32'(stat_stall_cnt), 32'd0);
    WFULL = 1'b0;
`endif

    // Randomized traffic with sticky requests, random backpressure and rare resets.
    do_reset();
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) req = 4'($urandom_range(0, 15));
      WFULL = ($urandom_range(0, 3) == 0);
      WRST = ($urandom_range(0, 99) == 0);
      req_data = $urandom;
      settle();
      advance();
    end
    WRST = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
